// File: rtl/ysyx_23060136_idu_issue_stage.sv
// ---------------------------------------------------------------------------
// ysyx_23060136_idu_issue_stage
//
// Registers one decoded instruction between IFU and EXU with valid/ready
// handshakes on both sides. Holds the integer register file (one write-back
// port) and a per-register counter scoreboard of issued-but-unretired writes.
// RAW hazards and scoreboard-counter overflow stall the input. EXU therefore
// always receives final operand values, and no forwarding network is needed.
//
// Optional feature macro: YSYX_23060136_IDU_BYPASS_EN
//   Defined   : a source whose only pending write retires in the current cycle
//               is not a hazard. The operand comes from wb_data, or from the
//               register file if the retire is a kill.
//   Undefined : the source stalls until its counter reads 0.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   in_valid/in_ready IFU handshake; in_pc, in_inst instruction from IFU
//   out_valid/out_ready EXU handshake; out_pc, out_inst, out_rd, out_rd_wr,
//                     out_rs1_data, out_rs2_data registered issue payload
//   flush             kill held and incoming instruction
//   wb_valid, wb_rd, wb_we, wb_data  retire of one tracked write
//   sb_busy           any scoreboard counter non-zero
// ---------------------------------------------------------------------------
module ysyx_23060136_idu_issue_stage #(
    parameter int XLEN     = 64,
    parameter int INST_W   = 32,
    parameter int GPR_NUM  = 32,
    parameter int SB_CNT_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [INST_W-1:0]          in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [INST_W-1:0]          out_inst,
    output logic [$clog2(GPR_NUM)-1:0] out_rd,
    output logic                       out_rd_wr,
    output logic [XLEN-1:0]            out_rs1_data,
    output logic [XLEN-1:0]            out_rs2_data,
    input  logic                       flush,
    input  logic                       wb_valid,
    input  logic [$clog2(GPR_NUM)-1:0] wb_rd,
    input  logic                       wb_we,
    input  logic [XLEN-1:0]            wb_data,
    output logic                       sb_busy
);
    localparam int RW = $clog2(GPR_NUM);
    localparam logic [SB_CNT_W-1:0] SB_ONE    = SB_CNT_W'(1);
    localparam logic [SB_CNT_W-1:0] SB_MAX    = {SB_CNT_W{1'b1}};
    localparam logic [SB_CNT_W-1:0] SB_MAX_M1 = SB_MAX - SB_ONE;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32= 7'b0011011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    // Issue register
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic [RW-1:0]     out_rd_q, out_rd_d;
    logic              out_rd_wr_q, out_rd_wr_d;
    logic [XLEN-1:0]   out_rs1_data_q, out_rs1_data_d;
    logic [XLEN-1:0]   out_rs2_data_q, out_rs2_data_d;

    // Scoreboard and register file
    logic [SB_CNT_W-1:0] sb_cnt_q [GPR_NUM];
    logic [SB_CNT_W-1:0] sb_cnt_d [GPR_NUM];
    logic [XLEN-1:0]     gpr_q    [GPR_NUM];
    logic [XLEN-1:0]     gpr_d    [GPR_NUM];
    logic [GPR_NUM-1:0]  sb_inc, sb_dec, sb_nz, gpr_we;

    // Decode
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [RW-1:0] dec_rd;
    logic          use_rd, dec_rd_wr;
    logic [RW-1:0] src_idx [2];
    logic          src_use [2];
    logic [XLEN-1:0] src_val [2];
    logic [1:0]    src_haz;
    logic          sat_haz, hazard, held_wr, capture, out_fire;

    assign opcode     = in_inst[6:0];
    assign funct3     = in_inst[14:12];
    assign dec_rd     = in_inst[7 +: RW];
    assign src_idx[0] = in_inst[15 +: RW];
    assign src_idx[1] = in_inst[20 +: RW];

    always_comb begin
        src_use[0] = 1'b0;
        src_use[1] = 1'b0;
        use_rd     = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: use_rd = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32: begin
                src_use[0] = 1'b1;
                use_rd     = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                src_use[0] = 1'b1;
                src_use[1] = 1'b1;
            end
            OPC_OP, OPC_OP32: begin
                src_use[0] = 1'b1;
                src_use[1] = 1'b1;
                use_rd     = 1'b1;
            end
            OPC_SYSTEM: begin
                // funct3 == 0 is ECALL/EBREAK/xRET: no register fields
                if (funct3 != 3'b000) begin
                    src_use[0] = 1'b1;
                    use_rd     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign dec_rd_wr = use_rd && (dec_rd != '0);

    // The held instruction's write is not yet in the scoreboard, but it will
    // be before anything captured now can issue, so it counts as pending.
    assign held_wr = out_valid_q && out_rd_wr_q;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_haz[s] = 1'b0;
            src_val[s] = '0;
            if (src_use[s] && (src_idx[s] != '0)) begin
                src_val[s] = gpr_q[src_idx[s]];
                if (held_wr && (out_rd_q == src_idx[s])) begin
                    src_haz[s] = 1'b1;
`ifdef YSYX_23060136_IDU_BYPASS_EN
                end else if ((sb_cnt_q[src_idx[s]] == SB_ONE) && wb_valid &&
                             (wb_rd == src_idx[s])) begin
                    if (wb_we) src_val[s] = wb_data;
`endif
                end else if (sb_cnt_q[src_idx[s]] != '0) begin
                    src_haz[s] = 1'b1;
                end
            end
        end
    end

    // Counter overflow guard, again counting the held writer as pending.
    assign sat_haz = dec_rd_wr &&
                     ((sb_cnt_q[dec_rd] == SB_MAX) ||
                      ((sb_cnt_q[dec_rd] == SB_MAX_M1) && held_wr && (out_rd_q == dec_rd)));

    assign hazard   = src_haz[0] | src_haz[1] | sat_haz;
    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign capture  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_inst_d     = out_inst_q;
        out_rd_d       = out_rd_q;
        out_rd_wr_d    = out_rd_wr_q;
        out_rs1_data_d = out_rs1_data_q;
        out_rs2_data_d = out_rs2_data_q;
        if (capture) begin
            out_valid_d    = 1'b1;
            out_pc_d       = in_pc;
            out_inst_d     = in_inst;
            out_rd_d       = dec_rd;
            out_rd_wr_d    = dec_rd_wr;
            out_rs1_data_d = src_val[0];
            out_rs2_data_d = src_val[1];
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (flush) out_valid_d = 1'b0;
    end

    for (genvar gi = 0; gi < GPR_NUM; gi++) begin : g_reg
        assign sb_inc[gi] = out_fire && out_rd_wr_q && (out_rd_q == RW'(gi));
        assign sb_dec[gi] = wb_valid && (gi != 0) && (wb_rd == RW'(gi));
        assign gpr_we[gi] = sb_dec[gi] && wb_we;
        assign sb_nz[gi]  = |sb_cnt_q[gi];
    end

    assign sb_busy = |sb_nz;

    always_comb begin
        for (int r = 0; r < GPR_NUM; r++) begin
            sb_cnt_d[r] = sb_cnt_q[r];
            gpr_d[r]    = gpr_we[r] ? wb_data : gpr_q[r];
            if (sb_inc[r] && !sb_dec[r]) begin
                sb_cnt_d[r] = sb_cnt_q[r] + SB_ONE;
            end else if (sb_dec[r] && !sb_inc[r] && (sb_cnt_q[r] != '0)) begin
                sb_cnt_d[r] = sb_cnt_q[r] - SB_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_inst_q     <= '0;
            out_rd_q       <= '0;
            out_rd_wr_q    <= 1'b0;
            out_rs1_data_q <= '0;
            out_rs2_data_q <= '0;
            for (int r = 0; r < GPR_NUM; r++) begin
                sb_cnt_q[r] <= '0;
                gpr_q[r]    <= '0;
            end
        end else begin
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_inst_q     <= out_inst_d;
            out_rd_q       <= out_rd_d;
            out_rd_wr_q    <= out_rd_wr_d;
            out_rs1_data_q <= out_rs1_data_d;
            out_rs2_data_q <= out_rs2_data_d;
            for (int r = 0; r < GPR_NUM; r++) begin
                sb_cnt_q[r] <= sb_cnt_d[r];
                gpr_q[r]    <= gpr_d[r];
            end
        end
    end

    // A retire for a register with nothing outstanding means the downstream
    // pipeline lost track of an instruction; the counter is left at 0.
    always_ff @(posedge clk) begin
        if (rst && wb_valid && (wb_rd != '0)) begin
            assert (sb_cnt_q[wb_rd] != '0);
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_inst     = out_inst_q;
    assign out_rd       = out_rd_q;
    assign out_rd_wr    = out_rd_wr_q;
    assign out_rs1_data = out_rs1_data_q;
    assign out_rs2_data = out_rs2_data_q;

endmodule

// File: tb/tb_ysyx_23060136_idu_issue_stage.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060136_idu_issue_stage (default parameters).
// Directed scenarios followed by randomized traffic, checked every cycle
// against a reference model of pending writes, register values and the
// held instruction.
// ---------------------------------------------------------------------------
module tb_ysyx_23060136_idu_issue_stage;
    localparam int SB_MAX = 3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rd;
    logic        out_rd_wr;
    logic [63:0] out_rs1_data;
    logic [63:0] out_rs2_data;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [63:0] wb_data;
    logic        sb_busy;

    ysyx_23060136_idu_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rd(out_rd), .out_rd_wr(out_rd_wr),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
        .wb_data(wb_data), .sb_busy(sb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model
    int          m_cnt [32];
    logic [63:0] m_gpr [32];
    bit          m_hv, m_wr;
    logic [63:0] m_pc, m_r1, m_r2;
    logic [31:0] m_inst;
    int          m_rd;
    int          inflight[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            m_cnt[r] = 0;
            m_gpr[r] = '0;
        end
        m_hv = 0; m_wr = 0; m_pc = '0; m_inst = '0; m_rd = 0; m_r1 = '0; m_r2 = '0;
        inflight.delete();
    endfunction

    function automatic void decode(input logic [31:0] inst, output bit u1, output bit u2, output bit ud);
        u1 = 0; u2 = 0; ud = 0;
        case (inst[6:0])
            7'h37, 7'h17, 7'h6f:        ud = 1;
            7'h67, 7'h03, 7'h13, 7'h1b: begin u1 = 1; ud = 1; end
            7'h63, 7'h23:               begin u1 = 1; u2 = 1; end
            7'h33, 7'h3b:               begin u1 = 1; u2 = 1; ud = 1; end
            7'h73: if (inst[14:12] != 3'b000) begin u1 = 1; ud = 1; end
            default: ;
        endcase
    endfunction

    // Writes to r not yet retired, including the one waiting in the output slot.
    function automatic int pend(input int r);
        return m_cnt[r] + ((m_hv && m_wr && m_rd == r) ? 1 : 0);
    endfunction

    task automatic model_eval(output bit rdy, output bit wr,
                              output logic [63:0] v1, output logic [63:0] v2);
        bit u1, u2, ud, haz;
        int rs [2];
        bit us [2];
        logic [63:0] v [2];
        int rd;
        decode(in_inst, u1, u2, ud);
        rs[0] = int'(in_inst[19:15]);
        rs[1] = int'(in_inst[24:20]);
        us[0] = u1;
        us[1] = u2;
        rd    = int'(in_inst[11:7]);
        haz   = 0;
        for (int s = 0; s < 2; s++) begin
            v[s] = '0;
            if (us[s] && rs[s] != 0) begin
                v[s] = m_gpr[rs[s]];
`ifdef YSYX_23060136_IDU_BYPASS_EN
                if (pend(rs[s]) == 1 && m_cnt[rs[s]] == 1 && wb_valid && int'(wb_rd) == rs[s]) begin
                    if (wb_we) v[s] = wb_data;
                end else
`endif
                if (pend(rs[s]) != 0) haz = 1;
            end
        end
        if (ud && rd != 0 && pend(rd) >= SB_MAX) haz = 1;
        wr  = ud && (rd != 0);
        rdy = (!m_hv || out_ready) && !haz && !flush;
        v1  = v[0];
        v2  = v[1];
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit rdy, wr, fire, cap, busy;
        logic [63:0] v1, v2;
        @(negedge clk);
        model_eval(rdy, wr, v1, v2);
        busy = 0;
        for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) busy = 1;
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("sb_busy", 64'(sb_busy), 64'(busy));
        check("out_valid", 64'(out_valid), 64'(m_hv));
        check("out_pc", out_pc, m_pc);
        check("out_inst", 64'(out_inst), 64'(m_inst));
        check("out_rd", 64'(out_rd), 64'(m_rd));
        check("out_rd_wr", 64'(out_rd_wr), 64'(m_wr));
        check("out_rs1_data", out_rs1_data, m_r1);
        check("out_rs2_data", out_rs2_data, m_r2);
        fire = m_hv && out_ready;
        cap  = in_valid && rdy;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (fire) begin
                $display("issue pc=%h inst=%h rd=%0d rd_wr=%0b rs1=%h rs2=%h",
                         m_pc, m_inst, m_rd, m_wr, m_r1, m_r2);
                if (m_wr) begin
                    m_cnt[m_rd]++;
                    inflight.push_back(m_rd);
                end
            end
            if (wb_valid && wb_rd != 0) begin
                if (m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
                if (wb_we) m_gpr[wb_rd] = wb_data;
            end
            if (cap) begin
                m_hv = 1; m_pc = in_pc; m_inst = in_inst; m_rd = int'(in_inst[11:7]);
                m_wr = wr; m_r1 = v1; m_r2 = v2;
            end else if (fire) begin
                m_hv = 0;
            end
            if (flush) m_hv = 0;
        end
        #1;
    endtask

    function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] i_add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] i_lui(input int rd);
        return {20'h12345, 5'(rd), 7'b0110111};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  opc;
        w = $urandom;
        case ($urandom_range(0, 12))
            0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6f;  3: opc = 7'h67;
            4: opc = 7'h03;  5: opc = 7'h13;  6: opc = 7'h1b;  7: opc = 7'h63;
            8: opc = 7'h23;  9: opc = 7'h33; 10: opc = 7'h3b; 11: opc = 7'h73;
            default: opc = 7'h0b;
        endcase
        w[6:0]   = opc;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; in_valid = 0; in_pc = '0; in_inst = '0; out_ready = 1; flush = 0;
        wb_valid = 0; wb_rd = '0; wb_we = 0; wb_data = '0;
        model_reset();
        @(posedge clk); #1;
        cycle();
        cycle();

        // First issue: addi x5,x0,7
        rst = 1; in_valid = 1; in_pc = 64'h8000_0000; in_inst = i_addi(5, 0, 7); out_ready = 0;
        cycle();
        check("tp1_valid", 64'(out_valid), 64'd1);
        check("tp1_rd", 64'(out_rd), 64'd5);
        check("tp1_rd_wr", 64'(out_rd_wr), 64'd1);
        check("tp1_rs1", out_rs1_data, 64'd0);
        in_valid = 0; out_ready = 1;
        cycle();
        check("tp1_busy", 64'(sb_busy), 64'd1);

        // RAW on x5, released by its retire
        in_valid = 1; in_pc = 64'h8000_0004; in_inst = i_add(6, 5, 5);
        cycle();
        cycle();
        check("tp2_stalled", 64'(out_valid), 64'd0);
        wb_valid = 1; wb_rd = 5; wb_we = 1; wb_data = 64'd7;
        cycle();
        wb_valid = 0;
`ifndef YSYX_23060136_IDU_BYPASS_EN
        cycle();
`endif
        in_valid = 0;
        check("tp2_valid", 64'(out_valid), 64'd1);
        check("tp2_rs1", out_rs1_data, 64'd7);
        check("tp2_rs2", out_rs2_data, 64'd7);
        cycle();
        wb_valid = 1; wb_rd = 6; wb_we = 1; wb_data = 64'h66;
        cycle();
        wb_valid = 0;

        // Three outstanding writers of x3 saturate its counter
        in_valid = 1; in_pc = 64'h8000_0010; in_inst = i_addi(3, 0, 1);
        repeat (6) cycle();
        check("tp3_stalled", 64'(out_valid), 64'd0);
        wb_valid = 1; wb_rd = 3; wb_we = 1; wb_data = 64'h33;
        cycle();
        wb_valid = 0;
        cycle();
        check("tp3_fourth", 64'(out_valid), 64'd1);
        in_valid = 0;
        cycle();

        // Backpressure hold, then flush
        out_ready = 0; in_valid = 1; in_pc = 64'h8000_0020; in_inst = i_addi(7, 0, 9);
        cycle();
        in_pc = 64'h8000_0024; in_inst = i_lui(8);
        repeat (5) cycle();
        check("tp4_held_inst", 64'(out_inst), 64'(i_addi(7, 0, 9)));
        flush = 1;
        cycle();
        flush = 0; in_valid = 0; out_ready = 1;
        check("tp4_flush_valid", 64'(out_valid), 64'd0);
        in_valid = 1; in_pc = 64'h8000_0028; in_inst = i_add(12, 7, 7);
        cycle();
        check("tp4_no_x7_pending", 64'(out_valid), 64'd1);
        in_valid = 0;
        cycle();

        // Killed writer of x9 keeps the old value; writes to x0 are dropped
        in_valid = 1; in_pc = 64'h8000_0030; in_inst = i_addi(9, 0, 5);
        cycle();
        in_valid = 0;
        cycle();
        wb_valid = 1; wb_rd = 9; wb_we = 1; wb_data = 64'h1234;
        cycle();
        wb_valid = 0; in_valid = 1;
        cycle();
        in_valid = 0;
        cycle();
        wb_valid = 1; wb_rd = 9; wb_we = 0; wb_data = 64'hdead;
        cycle();
        wb_valid = 0; in_valid = 1; in_inst = i_add(10, 9, 0);
        cycle();
        in_valid = 0;
        check("tp5_x9_kept", out_rs1_data, 64'h1234);
        cycle();
        wb_valid = 1; wb_rd = 0; wb_we = 1; wb_data = 64'hFFFF;
        cycle();
        wb_valid = 0; in_valid = 1; in_inst = i_add(11, 0, 0);
        cycle();
        in_valid = 0;
        check("tp5_x0_rs1", out_rs1_data, 64'd0);
        check("tp5_x0_rs2", out_rs2_data, 64'd0);
        cycle();

        // Reset in the middle of a stall clears the scoreboard
        in_valid = 1; in_pc = 64'h8000_0040; in_inst = i_add(13, 3, 3);
        cycle();
        cycle();
        rst = 0;
        cycle();
        rst = 1;
        check("tp6_busy", 64'(sb_busy), 64'd0);
        check("tp6_valid", 64'(out_valid), 64'd0);
        cycle();
        check("tp6_capture", 64'(out_valid), 64'd1);
        in_valid = 0;
        cycle();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pc     = {$urandom, $urandom};
            in_inst   = rand_inst();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_valid = 1;
                wb_rd    = 5'(inflight.pop_front());
            end else begin
                wb_valid = 0;
                wb_rd    = 5'($urandom_range(0, 31));
            end
            wb_we   = ($urandom_range(0, 4) != 0);
            wb_data = {$urandom, $urandom};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_23060136_idu_issue_stage.md
Name: ysyx_23060136_idu_issue_stage

Overview:
Parametrised, pipelined successor of the combinational IDU. The block registers one decoded instruction between IFU and EXU using valid/ready handshakes on both sides. It owns the integer register file (one WB write port), and tracks per-register pending writes with a counter scoreboard. It stalls RAW and WAW-overflow hazards, so EXU always receives final operand values without a forwarding network.

Parameters:
XLEN, 64, datapath/register width
INST_W, 32, instruction width
GPR_NUM, 32, number of integer registers (x0 hardwired to 0)
SB_CNT_W, 2, scoreboard counter width; max 2^SB_CNT_W-1 outstanding writes per register

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
in_valid  in  1  IFU instruction valid
in_ready  out  1  stage accepts instruction this cycle
in_pc  in  XLEN  instruction PC
in_inst  in  INST_W  instruction word
out_valid  out  1  registered instruction valid to EXU
out_ready  in  1  EXU accepts
out_pc  out  XLEN  registered PC
out_inst  out  INST_W  registered instruction
out_rd  out  log2(GPR_NUM)  destination register
out_rd_wr  out  1  instruction writes rd != 0 (tracked by scoreboard)
out_rs1_data  out  XLEN  rs1 operand (0 if unused)
out_rs2_data  out  XLEN  rs2 operand (0 if unused)
flush  in  1  kill the held instruction and the incoming one
wb_valid  in  1  retire of one tracked instruction (one per issued out_rd_wr=1)
wb_rd  in  log2(GPR_NUM)  retiring rd
wb_we  in  1  retire actually writes (0 = killed downstream)
wb_data  in  XLEN  write data
sb_busy  out  1  any scoreboard counter non-zero

Behaviour:
- Reset (rst=0 at clk edge): out_valid=0; out_pc/out_inst/out_rd/out_rs*_data=0; out_rd_wr=0; all scoreboard counters=0; GPR contents=0; sb_busy=0.
- Field usage by opcode[6:0]:
  - LUI, AUIPC, JAL: rd only.
  - JALR, LOAD, OP-IMM, OP-IMM-32: rs1 and rd.
  - BRANCH, STORE: rs1 and rs2.
  - OP, OP-32: rs1, rs2 and rd.
  - SYSTEM with funct3!=0: rs1 and rd.
  - SYSTEM with funct3=0, and any other opcode: none.
  - rd=x0 never tracked.
- Hazard (combinational from in_inst, independent of in_valid):
  - A used rs (non-x0) with counter!=0.
  - The used rs equals the rd of the held instruction when out_valid && out_rd_wr.
  - A writer whose rd counter is at max (saturation).
- Ready rule: in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Capture: on in_valid && in_ready, register pc/inst/rd/rd_wr and read operands. out_valid=1 next cycle, so latency is 1 cycle.
- If out fires without a capture, out_valid=0 next cycle. Outputs hold stable while out_valid && !out_ready.
- Scoreboard:
  - The counter[rd] increments on out fire when out_rd_wr=1.
  - The counter[wb_rd] decrements on wb_valid.
  - Increment and decrement of the same register in one cycle leave it unchanged.
  - wb_valid on a zero counter is an error; the counter stays 0 (assertion in simulation).
- GPR write: when wb_valid && wb_we && wb_rd!=0, write takes effect next cycle. x0 always reads 0.
- Flush:
  - Next cycle out_valid=0.
  - in_ready=0 during flush.
  - The scoreboard is untouched, because the held instruction was never issued.
  - Same-cycle out fire and flush: the fire counts (increment happens) and the flush wins for out_valid.
- sb_busy = OR of all counters != 0.

Optional Feature:
YSYX_23060136_IDU_BYPASS_EN
- Defined: a rs with counter==1 and same-cycle wb_valid && wb_rd==rs is not a hazard. The operand is taken from wb_data if wb_we, else from the register file.
- Undefined: no bypass; the instruction stalls until the counter reads 0, so the write is visible one cycle after retire.

Test Plan:
- Reset, then in_valid=1 with inst=addi x5,x0,7 at pc=0x80000000 → next cycle out_valid=1, out_rd=5, out_rd_wr=1, out_rs1_data=0. Out fire → counter[5]=1 and sb_busy=1.
- Issue addi x5, then present add x6,x5,x5 → in_ready=0. Then wb_valid=1, wb_rd=5, wb_we=1, wb_data=7 → in_ready=1 in the same cycle (bypass build) or the next cycle (no bypass). Captured out_rs1_data = out_rs2_data = 7.
- SB_CNT_W=2: three writers of x3 issued without retire, a fourth presented → in_ready=0 until one wb_valid for x3.
- out_ready=0 for 5 cycles with an instruction held → outputs stable and in_ready=0. Then flush=1 → out_valid=0 next cycle and counters unchanged.
- wb_valid=1, wb_we=0 for a killed writer of x9 → counter[9] decrements and the x9 value is unchanged. A write with wb_rd=0, wb_data=0xFFFF → x0 still reads 0.
- Assert rst=0 mid-stall with counters non-zero → next cycle all counters=0, out_valid=0, sb_busy=0.
